display_scan_ctrl: RTL and testbench

Selection sequencer for the seven-segment register viewer. It produces the 5-bit register index and the low/high half-word select that drive the register-display mux. There are four modes: manual (switches), auto-scan (timed dwell), single-step (debounced push-button) and hold. It sits between the board switches/buttons and the display datapath, replacing the direct switch-to-mux wiring.

---
 rtl/display_scan_ctrl.sv | 89 ++++++++
 tb/tb_display_scan_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: register-viewer selection sequencer (manual/auto/step/hold); SCAN_SKIP_R0_EN skips r0 in auto/step
module display_scan_ctrl #(
  parameter int DWELL_CYCLES    = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [4:0] sw_sel,
  input  logic       sw_half,
  input  logic       step_btn,
  output logic [4:0] reg_sel,
  output logic       half_sel,
  output logic       sel_changed,
  output logic       scan_wrap
);
  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int BW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {S_MANUAL = 2'b00, S_AUTO = 2'b01, S_STEP = 2'b10, S_HOLD = 2'b11} state_e;
  state_e          state_q, state_d;
  logic [5:0]      p_q, p_d, p_inc, p_adv;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [BW-1:0]   deb_q, deb_d;
  logic            sync1_q, sync2_q, db_q, db_d, db_prev_q;
  logic            chg_q, wrap_q, wrap_d, wrap_adv, adv, rise;
  // button synchronizer, debounce counter and edge-detect history
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
    end else begin
      sync1_q   <= step_btn;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
    end
  end
  // debounced level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    deb_d = (sync2_q == db_q || deb_q == DEB_LAST) ? '0 : deb_q + 1'b1;
    db_d  = (sync2_q != db_q && deb_q == DEB_LAST) ? sync2_q : db_q;
    rise  = db_q & ~db_prev_q;
  end
  // state, position, dwell counter and registered pulse outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_MANUAL;
      p_q     <= '0;
      dwell_q <= '0;
      chg_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      dwell_q <= dwell_d;
      chg_q   <= p_d != p_q;
      wrap_q  <= wrap_d;
    end
  end
  // next state follows mode; an advance needs the old and new state to agree so a mode change wins
  always_comb begin
    state_d = state_e'(mode);
    p_inc   = p_q + 6'd1;
`ifdef SCAN_SKIP_R0_EN
    wrap_adv = p_inc[5:1] == 5'd0;
    p_adv    = wrap_adv ? 6'd2 : p_inc;
`else
    wrap_adv = &p_q;
    p_adv    = p_inc;
`endif
    adv = (state_d == S_AUTO && state_q == S_AUTO && dwell_q == DWELL_LAST) ||
          (state_d == S_STEP && state_q == S_STEP && rise);
    dwell_d = (state_d == S_HOLD) ? dwell_q :
              (state_d != S_AUTO) ? '0 :
              (state_q != S_AUTO) ? DW'(1) :
              (dwell_q == DWELL_LAST) ? '0 : dwell_q + 1'b1;
    p_d    = (state_d == S_MANUAL) ? {sw_sel, sw_half} : adv ? p_adv : p_q;
    wrap_d = adv & wrap_adv;
  end
  assign {reg_sel, half_sel} = p_q;
  assign sel_changed = chg_q;
  assign scan_wrap   = wrap_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed scenarios plus randomized run against a behavioural model
module tb_display_scan_ctrl;
  localparam int DWELL = 4;
  localparam int DEB   = 3;
`ifdef SCAN_SKIP_R0_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] mode = 2'd1;
  logic [4:0] sw_sel = 5'd0;
  logic       sw_half = 1'b0;
  logic       step_btn = 1'b0;
  logic [4:0] reg_sel;
  logic       half_sel, sel_changed, scan_wrap;
  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] m_p;
  logic       m_chg, m_wrap, m_db, m_rose;
  logic [1:0] m_prev;
  int         m_run;
  logic       m_hist [0:7];

  always #5 clk = ~clk;

  display_scan_ctrl #(.DWELL_CYCLES(DWELL), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sw_sel(sw_sel), .sw_half(sw_half),
    .step_btn(step_btn), .reg_sel(reg_sel), .half_sel(half_sel),
    .sel_changed(sel_changed), .scan_wrap(scan_wrap)
  );

  // behavioural model evaluated at each rising edge from the inputs in effect
  task automatic model_step();
    logic [5:0] np;
    logic w, adv, all_diff, rise_now;
    if (!reset) begin
      m_p = 0; m_chg = 0; m_wrap = 0; m_db = 0; m_rose = 0; m_prev = 0; m_run = 0;
      for (int i = 0; i < 8; i++) m_hist[i] = 1'b0;
    end else begin
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++) if (m_hist[1+j] == m_db) all_diff = 1'b0;
      rise_now = m_rose;
      m_rose = all_diff && !m_db;
      if (all_diff) m_db = !m_db;
      m_run = (mode == 2'd1) ? m_run + 1 : 0;
      adv = (mode == 2'd1 && m_run % DWELL == 0) || (mode == 2'd2 && m_prev == 2'd2 && rise_now);
      np = m_p;
      w = 1'b0;
      if (mode == 2'd0) np = {sw_sel, sw_half};
      else if (adv) begin
        np = m_p + 6'd1;
        w = (m_p == 6'd63);
        if (SKIP && np < 6'd2) begin np = 6'd2; w = 1'b1; end
      end
      m_chg = (np != m_p);
      m_p = np;
      m_wrap = w;
      m_prev = mode;
      for (int i = 7; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = step_btn;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic set_manual(input logic [4:0] s, input logic h);
    mode = 2'd0; sw_sel = s; sw_half = h;
    tick(1);
  endtask

  task automatic test_reset();
    tick(2);
    n_cmp++; if ({reg_sel, half_sel, sel_changed, scan_wrap} !== 8'd0) begin n_bad++; $display("FAIL reset_state got %b want 0", {reg_sel, half_sel, sel_changed, scan_wrap}); end
    reset = 1'b1;
    tick(3);
    n_cmp++; if ({reg_sel, half_sel} !== 6'd0) begin n_bad++; $display("FAIL reset_hold_p got %0d want 0", {reg_sel, half_sel}); end
    tick(1);
    n_cmp++; if ({reg_sel, half_sel, sel_changed} !== {6'd1, 1'b1}) begin n_bad++; $display("FAIL reset_first_adv got %b want 0000011", {reg_sel, half_sel, sel_changed}); end
  endtask

  task automatic test_manual();
    set_manual(5'd17, 1'b1);
    n_cmp++; if ({reg_sel, half_sel, sel_changed} !== {5'd17, 1'b1, 1'b1}) begin n_bad++; $display("FAIL manual_load got %b want 1000111", {reg_sel, half_sel, sel_changed}); end
    tick(1);
    n_cmp++; if ({reg_sel, half_sel, sel_changed} !== {5'd17, 1'b1, 1'b0}) begin n_bad++; $display("FAIL manual_steady got %b want 1000110", {reg_sel, half_sel, sel_changed}); end
    tick(3);
    n_cmp++; if ({sel_changed, scan_wrap} !== 2'b00) begin n_bad++; $display("FAIL manual_no_pulse got %b want 00", {sel_changed, scan_wrap}); end
  endtask

  task automatic test_auto_wrap();
    logic [5:0] wrap_to;
    wrap_to = SKIP ? 6'd2 : 6'd0;
    set_manual(5'd31, 1'b0);
    mode = 2'd1;
    tick(3);
    n_cmp++; if ({reg_sel, half_sel} !== 6'd62) begin n_bad++; $display("FAIL auto_dwell got %0d want 62", {reg_sel, half_sel}); end
    tick(1);
    n_cmp++; if ({reg_sel, half_sel, sel_changed, scan_wrap} !== {6'd63, 2'b10}) begin n_bad++; $display("FAIL auto_r31h got %b want 11111110", {reg_sel, half_sel, sel_changed, scan_wrap}); end
    tick(3);
    n_cmp++; if ({reg_sel, half_sel} !== 6'd63) begin n_bad++; $display("FAIL auto_dwell2 got %0d want 63", {reg_sel, half_sel}); end
    tick(1);
    n_cmp++; if ({reg_sel, half_sel, sel_changed, scan_wrap} !== {wrap_to, 2'b11}) begin n_bad++; $display("FAIL auto_wrap got %b want %b", {reg_sel, half_sel, sel_changed, scan_wrap}, {wrap_to, 2'b11}); end
    tick(1);
    n_cmp++; if (scan_wrap !== 1'b0) begin n_bad++; $display("FAIL auto_wrap_pulse got %b want 0", scan_wrap); end
  endtask

  task automatic test_step_bounce();
    set_manual(5'd5, 1'b0);
    mode = 2'd2;
    tick(2);
    step_btn = 1'b1; tick(1);
    step_btn = 1'b0; tick(1);
    step_btn = 1'b1;
    tick(5);
    n_cmp++; if ({reg_sel, half_sel} !== 6'd10) begin n_bad++; $display("FAIL step_early got %0d want 10", {reg_sel, half_sel}); end
    tick(1);
    n_cmp++; if ({reg_sel, half_sel, sel_changed} !== {6'd11, 1'b1}) begin n_bad++; $display("FAIL step_adv got %b want 0010111", {reg_sel, half_sel, sel_changed}); end
    tick(10);
    n_cmp++; if ({reg_sel, half_sel} !== 6'd11) begin n_bad++; $display("FAIL step_single got %0d want 11", {reg_sel, half_sel}); end
    step_btn = 1'b0;
    tick(8);
    n_cmp++; if ({reg_sel, half_sel} !== 6'd11) begin n_bad++; $display("FAIL step_release got %0d want 11", {reg_sel, half_sel}); end
  endtask

  task automatic test_hold();
    set_manual(5'd3, 1'b0);
    mode = 2'd1;
    tick(2);
    mode = 2'd3;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      n_cmp++; if ({reg_sel, half_sel, sel_changed} !== {6'd6, 1'b0}) begin n_bad++; $display("FAIL hold_frozen got %b want 0001100", {reg_sel, half_sel, sel_changed}); end
    end
    mode = 2'd1;
    tick(3);
    n_cmp++; if ({reg_sel, half_sel} !== 6'd6) begin n_bad++; $display("FAIL hold_resume_early got %0d want 6", {reg_sel, half_sel}); end
    tick(1);
    n_cmp++; if ({reg_sel, half_sel, sel_changed} !== {6'd7, 1'b1}) begin n_bad++; $display("FAIL hold_resume_adv got %b want 0001111", {reg_sel, half_sel, sel_changed}); end
  endtask

  task automatic test_boundaries();
    set_manual(5'd10, 1'b0);
    mode = 2'd1;
    tick(3);
    mode = 2'd2;
    tick(1);
    n_cmp++; if ({reg_sel, half_sel, sel_changed} !== {6'd20, 1'b0}) begin n_bad++; $display("FAIL mode_wins got %b want 0101000", {reg_sel, half_sel, sel_changed}); end
    tick(3);
    n_cmp++; if ({reg_sel, half_sel} !== 6'd20) begin n_bad++; $display("FAIL mode_wins_after got %0d want 20", {reg_sel, half_sel}); end
    set_manual(5'd9, 1'b1);
    mode = 2'd1;
    tick(2);
    reset = 1'b0;
    tick(1);
    n_cmp++; if ({reg_sel, half_sel, sel_changed, scan_wrap} !== 8'd0) begin n_bad++; $display("FAIL reset_mid got %b want 0", {reg_sel, half_sel, sel_changed, scan_wrap}); end
    reset = 1'b1;
    mode = 2'd0; sw_sel = 5'd0; sw_half = 1'b0;
    tick(1);
  endtask

  task automatic test_random();
    int len;
    for (int s = 0; s < 300; s++) begin
      mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin sw_sel = 5'($urandom); sw_half = 1'($urandom); end
      step_btn = 1'($urandom);
      reset = ($urandom_range(0, 39) != 0);
      len = $urandom_range(1, 12);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 5) == 0) step_btn = !step_btn;
        tick(1);
        reset = 1'b1;
        n_cmp++; if ({reg_sel, half_sel, sel_changed, scan_wrap} !== {m_p, m_chg, m_wrap}) begin n_bad++; $display("FAIL random got %b want %b", {reg_sel, half_sel, sel_changed, scan_wrap}, {m_p, m_chg, m_wrap}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto_wrap();
    test_step_bounce();
    test_hold();
    test_boundaries();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
